if_fetch_unit: RTL
==================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch stage for the 5-stage pipeline. Owns the PC register, issues one
//  outstanding instruction-memory request at a time, and buffers one fetched word.
//  Presents {IR, PC, commit, isHalt} to the IF/ID pipeline register.
//  Accepts stall from the hazard unit and branch/jump redirect from EX.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  HALT_INSN  32'h0010_0073  encoding that marks the halt instruction (ebreak)
//  NOP_IR     32'h0000_0000  IR value driven when no valid instruction is presented
// PORTS
//  clk           in   1   clock, all state updates on posedge
//  rst           in   1   reset; synchronous, active-high
//  stall         in   1   IF/ID holding this cycle; presented instruction not consumed
//  redirect_en   in   1   EX resolved taken branch/jump this cycle
//  redirect_pc   in   32  new fetch target; bits [1:0] forced to 0
//  imem_req      out  1   fetch request valid
//  imem_addr     out  32  fetch word address (equals pc)
//  imem_ready    in   1   memory accepts request this cycle (accept = req & ready)
//  imem_rvalid   in   1   response valid; exactly one per accepted request, >=1 cycle later
//  imem_rdata    in   32  fetched instruction word
//  IR            out  32  instruction to IF/ID (NOP_IR when commit=0)
//  PC            out  32  PC of IR (0 when commit=0)
//  commit        out  1   IR/PC hold a real instruction
//  isHalt        out  1   commit & (IR == HALT_INSN)
//  halted        out  1   fetch stopped after a halt instruction
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=FETCH, buf_valid=0, kill=0. Consequently imem_req=0
//   during the reset cycle, commit=0, isHalt=0, halted=0, IR=NOP_IR, PC=0.
//  State machine:
//   - FETCH: imem_req = ~redirect_en & (~buf_valid | ~stall).
//     On accept: req_pc<=pc, pc<=pc+4 (mod 2^32), go to WAIT.
//   - WAIT: imem_req=0. On imem_rvalid:
//     - kill=1: drop word, kill<=0, go to FETCH.
//     - otherwise: buf<={imem_rdata, req_pc}, buf_valid<=1. Go to HALT if
//       imem_rdata==HALT_INSN, else go to FETCH.
//   - HALT: imem_req=0, halted=1. Leaves only on redirect_en (go to FETCH).
//  Output buffer:
//   - Cleared (buf_valid<=0) on any cycle with ~stall unless refilled that same cycle.
//   - With stall, buffered contents held unchanged.
//   - A response never overwrites a valid, unconsumed buffer; guaranteed by request gating.
//  Redirect (highest priority, overrides stall on buf):
//   - pc<={redirect_pc[31:2],2'b00}; buf_valid<=0.
//   - In WAIT without rvalid this cycle: kill<=1.
//   - In WAIT with rvalid this cycle: word discarded; go to FETCH.
//   - In HALT: go to FETCH.
//   - No request is issued in the redirect cycle; first new request next cycle.
//  Latency: with imem_ready=1 and 1-cycle response, one instruction every 2 cycles.
//   commit rises the cycle after imem_rvalid.
//  rst asserted mid-WAIT: outstanding response after reset is ignored (state=FETCH drops
//   it); the bench must not return rvalid unsolicited otherwise.
// TESTING
//  1. rst high 2 cycles -> imem_req=0, commit=0, IR=0, PC=0. First req addr=0x0
//     after rst low.
//  2. Words 0x00500093,0x00a00113 at 0x0,0x4, ready=1, 1-cycle latency
//     -> commit with PC=0x0 then 0x4; IR matches; imem_addr 0x0,0x4,0x8.
//  3. stall held 3 cycles with buffered PC=0x4 -> IR/PC/commit constant; no new req;
//     release -> req addr 0x8 issued.
//  4. redirect_en, redirect_pc=0x103 while in WAIT for addr 0x8 -> late word dropped;
//     next req addr=0x100; commit next shows PC=0x100.
//  5. Fetch 0x00100073 at 0x10 -> isHalt=1 with PC=0x10; halted=1; no further imem_req;
//     redirect to 0x20 -> halted=0, req 0x20.
//  6. imem_ready=0 for 4 cycles -> imem_req stays 1, imem_addr stable, pc not advanced.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC and keeps one imem request outstanding at a time.
// Holds one fetched word and presents it to IF/ID as {IR, PC, commit, isHalt}.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_INSN = 32'h0010_0073,
    parameter logic [31:0] NOP_IR    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IR,
    output logic [31:0] PC,
    output logic        commit,
    output logic        isHalt,
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] buf_ir_q, buf_ir_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic        buf_valid_q, buf_valid_d;
    logic        kill_q, kill_d;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        buf_ir_d    = buf_ir_q;
        buf_pc_d    = buf_pc_q;
        buf_valid_d = stall ? buf_valid_q : 1'b0;
        kill_d      = kill_q;
        imem_req    = 1'b0;

        case (state_q)
            FETCH: begin
                // Only request when the buffer is guaranteed free by response time.
                imem_req = ~redirect_en & (~buf_valid_q | ~stall);
                if (imem_req && imem_ready) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = FETCH;
                    end else if (redirect_en) begin
                        state_d = FETCH;
                    end else begin
                        buf_ir_d    = imem_rdata;
                        buf_pc_d    = req_pc_q;
                        buf_valid_d = 1'b1;
                        state_d     = (imem_rdata == HALT_INSN) ? HALT : FETCH;
                    end
                end else if (redirect_en) begin
                    kill_d = 1'b1;
                end
            end
            HALT: begin
                if (redirect_en) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase

        // Redirect wins over stall: the buffered instruction is on the wrong path.
        if (redirect_en) begin
            pc_d        = redirect_pc & 32'hFFFF_FFFC;
            buf_valid_d = 1'b0;
        end

        if (rst) imem_req = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            req_pc_q    <= RESET_PC;
            buf_ir_q    <= NOP_IR;
            buf_pc_q    <= 32'd0;
            buf_valid_q <= 1'b0;
            kill_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            buf_ir_q    <= buf_ir_d;
            buf_pc_q    <= buf_pc_d;
            buf_valid_q <= buf_valid_d;
            kill_q      <= kill_d;
        end
    end

    assign imem_addr = pc_q;
    assign commit    = buf_valid_q;
    assign IR        = buf_valid_q ? buf_ir_q : NOP_IR;
    assign PC        = buf_valid_q ? buf_pc_q : 32'd0;
    assign isHalt    = buf_valid_q & (buf_ir_q == HALT_INSN);
    assign halted    = (state_q == HALT);

endmodule
